// File: rtl/soc_system_buttons_irq_if.sv
// Avalon-MM slave bus bundle for the buttons/switches input PIO.
//   address    : register word address (2 bits)
//   chipselect : slave select
//   read       : read strobe (readdata is driven every cycle regardless)
//   write      : write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (slave -> master)
interface soc_system_buttons_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_buttons_irq.sv
// Input PIO for board push-buttons/switches behind the lightweight HPS bridge.
// Each bit is synchronised (two flops), debounced by a per-bit stability
// counter, edge-detected with a selectable sense, captured sticky in a
// write-1-to-clear register, masked and OR-reduced to a level interrupt.
//
// Ports:
//   clk      : single clock domain for all logic
//   reset    : synchronous active-high reset
//   avs      : Avalon-MM slave (address, chipselect, read, write,
//              writedata, readdata); register map:
//                0 DATA (debounced, RO)   1 IRQ_MASK (RW)
//                2 EDGE_CAPTURE (W1C)     3 RAW synchronised input (RO)
//   in_port  : asynchronous raw inputs, WIDTH bits
//   irq      : registered active-high level interrupt
module soc_system_buttons_irq #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  soc_system_buttons_irq_if.slave   avs,
  input  logic [WIDTH-1:0]          in_port,
  output logic                      irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  // The counter starts at 0 on the first differing cycle, so hitting
  // DEBOUNCE_CYCLES-1 marks the DEBOUNCE_CYCLES-th consecutive differing cycle.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  typedef logic [CNT_W-1:0] cnt_t;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  cnt_t             cnt_q [WIDTH];
  cnt_t             cnt_d [WIDTH];
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic             wr_en;

  // read strobe and the writedata bits above WIDTH carry no information here
  logic unused_bus;
  assign unused_bus = avs.read ^ (^avs.writedata);

  function automatic logic [WIDTH-1:0] edge_select(input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] f);
    case (EDGE_MODE)
      1:       return f;
      2:       return r | f;
      default: return r;
    endcase
  endfunction

  // Stage: two-flop synchroniser
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // Stage: debouncer; any return to agreement restarts the qualification
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (DEBOUNCE_CYCLES == 0) begin
        deb_d[i] = sync2_q[i];
      end else if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Stage: edge detect, capture, mask and interrupt
  always_comb begin
    deb_dly_d = deb_q;
    rise      = deb_q & ~deb_dly_q;
    fall      = ~deb_q & deb_dly_q;
    ev        = edge_select(rise, fall);
    wr_en     = avs.chipselect & avs.write;

    mask_d = mask_q;
    if (wr_en && (avs.address == 2'd1)) begin
      mask_d = avs.writedata[WIDTH-1:0];
    end

    clr = '0;
    if (wr_en && (avs.address == 2'd2)) begin
      clr = avs.writedata[WIDTH-1:0];
    end

    // a new event in the same cycle as its clear keeps the bit set
    cap_d = (cap_q & ~clr) | ev;
    irq_d = |(cap_d & mask_d);
  end

  // Stage: registered read mux; reflects state before this cycle's write
  always_comb begin
    readdata_d = '0;
    case (avs.address)
      2'd0:    readdata_d[WIDTH-1:0] = deb_q;
      2'd1:    readdata_d[WIDTH-1:0] = mask_q;
      2'd2:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d[WIDTH-1:0] = sync2_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= RESET_VALUE;
      sync2_q    <= RESET_VALUE;
      deb_q      <= RESET_VALUE;
      deb_dly_q  <= RESET_VALUE;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: doc/soc_system_buttons_irq.md
Name: soc_system_buttons_irq

Overview:
Parametrised Avalon-MM input PIO, the successor to the plain button read port. Per bit it provides:
- two-flop synchroniser;
- counter-based debouncer;
- edge-capture register with selectable edge sense;
- interrupt mask;
- level IRQ to the HPS.

It sits between board push-buttons/switches and the lightweight HPS-to-FPGA bridge.

Parameters:
WIDTH, 4, number of input bits (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles before the debounced value changes; 0 = debouncer bypassed
EDGE_MODE, 0, edge sense: 0 rising, 1 falling, 2 any
RESET_VALUE, 0, WIDTH-bit reset value of the synchroniser flops and debounced state

Ports:
clk  in  1  system clock; all logic is in this single domain
reset  in  1  synchronous active-high reset
address  in  2  Avalon register word address
chipselect  in  1  Avalon slave select
read  in  1  Avalon read strobe (informational; readdata is always driven)
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
in_port  in  WIDTH  asynchronous raw inputs
irq  out  1  active-high level interrupt

Behaviour:
- One clock domain `clk`. Reset is synchronous, active-high, on `reset`: all state is updated only on posedge clk while reset=1.
- Reset values:
  - sync flops = RESET_VALUE; debounced state = RESET_VALUE;
  - debounce counters = 0;
  - irq_mask = 0; edge_capture = 0; readdata = 0; irq = 0.
- Synchroniser: sync1 <= in_port; sync2 <= sync1. There are 2 cycles from in_port to sync2.
- Debouncer, per bit i:
  - counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync2[i] == deb[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, deb[i] <= sync2[i] and the counter clears.
  - Net effect: a change must persist DEBOUNCE_CYCLES consecutive cycles. A glitch shorter than that leaves deb unchanged and resets the count.
  - DEBOUNCE_CYCLES=0: deb <= sync2 every cycle.
- Edge detect: compares deb with its 1-cycle-delayed copy deb_d (deb_d resets to RESET_VALUE, so no spurious edge after reset).
  - rise = deb & ~deb_d; fall = ~deb & deb_d.
  - ev selected by EDGE_MODE: rise, fall, or rise|fall.
- Edge capture:
  - edge_capture[i] sets on ev[i] and is sticky.
  - Write to address 2 (chipselect & write): bits with writedata[i]=1 clear; writedata[i]=0 leaves the bit unchanged.
  - Simultaneous clear and ev on the same bit: set wins (bit = 1).
- Registers (word address; bits above WIDTH read 0, writes ignored):
  - 0 DATA: debounced state deb, read-only (writes ignored).
  - 1 IRQ_MASK: read/write, WIDTH bits.
  - 2 EDGE_CAPTURE: read, write-1-to-clear.
  - 3 RAW: sync2, read-only, for diagnostics.
- readdata:
  - readdata <= zero-extended mux(address) every cycle when not in reset, so read latency is 1 cycle.
  - A read returns register contents as of the cycle the address was presented.
  - A write and read to the same register in the same cycle returns the pre-write value.
- irq <= |(edge_capture_next & irq_mask_next), registered.
  - irq asserts 1 cycle after the capturing edge when the bit is enabled.
  - irq deasserts 1 cycle after the clearing write, or after the mask write that disables the bit.
- Reset mid-debounce: counter and deb return to reset values. Any pending change must re-qualify for a full DEBOUNCE_CYCLES.
- WIDTH=32: no padding; all readdata bits are live.

Test Plan:
- Bench setup: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=0, RESET_VALUE=0.
- Reset: hold reset 3 cycles with in_port=4'hF → readdata=0, irq=0. After release, DATA reads 0 until in_port has been stable ≥6 cycles (2 sync + 4 debounce), then DATA=0xF. EDGE_CAPTURE=0xF; irq stays 0 because mask=0.
- Glitch rejection: in_port[0] pulses high for 3 cycles → DATA bit0 stays 0, EDGE_CAPTURE bit0 stays 0. A 4-cycle-or-longer pulse → DATA bit0=1, then back to 0 after the release qualifies.
- IRQ path: write IRQ_MASK=0x2; drive in_port[1] 0→1 and hold → EDGE_CAPTURE=0x2 and irq=1 one cycle later. Write 0x2 to addr 2 → irq=0 one cycle later and EDGE_CAPTURE=0.
- Clear/set collision: time the W1C write to addr 2 with writedata=0x1 to land in the same cycle bit0's rising edge is captured → EDGE_CAPTURE bit0 reads 1.
- Edge modes: rerun with EDGE_MODE=1, then EDGE_MODE=2, on a 0→1→0 pattern on bit3 → capture only on the fall for mode 1; capture on both edges for mode 2 (clear between edges to observe each).
- Register map: write 0xFFFFFFFF to addr 1 → read addr 1 = 0x0000000F. Write to addr 0 has no effect. Addr 3 tracks in_port with 2-cycle lag and no debounce.
